// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the issue channel
// toward the datapath. The fetch unit is the master; memory/datapath sit on the slave side.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        issue_ready;
   logic [31:0] instr;
   logic        we;

   modport master (
      output imem_req,
      output imem_addr,
      output instr,
      output we,
      input  imem_ack,
      input  imem_rdata,
      input  issue_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      input  instr,
      input  we,
      output imem_ack,
      output imem_rdata,
      output issue_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, fetches words over req/ack and issues each one
// to the datapath with a single-cycle we strobe; halts permanently on the ecall word.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] ECALL_WORD = 32'h0000_0073
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   instr_fetch_if.master bus,
   output logic [31:0]   pc,
   output logic [31:0]   icount,
   output logic          halted
);

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] icount_q, icount_d;
   logic        halted_q, halted_d;
   logic        req_q, req_d;
   logic        issue_fire;

   // The datapath samples instr on the same edge, so the strobe is a pure decode.
   assign issue_fire = (state_q == ISSUE) && bus.issue_ready;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      icount_d = icount_q;
      halted_d = halted_q;

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = REQ;
            end
         end
         REQ: begin
            // run is deliberately not looked at here: a started fetch always completes.
            if (bus.imem_ack) begin
               instr_d = bus.imem_rdata;
               if (bus.imem_rdata == ECALL_WORD) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (issue_fire) begin
               pc_d     = pc_q + 32'd4;
               icount_d = icount_q + 32'd1;
               state_d  = run ? REQ : IDLE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_d = (state_d == REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_WORD;
         icount_q <= 32'd0;
         halted_q <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         icount_q <= icount_d;
         halted_q <= halted_d;
         req_q    <= req_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.instr     = instr_q;
   assign bus.we        = issue_fire;
   assign pc            = pc_q;
   assign icount        = icount_q;
   assign halted        = halted_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that produces the `instr`/`we` stream consumed by the single-cycle ALU datapath. It holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each word to the datapath with a one-cycle write-back enable once the datapath signals readiness. It sits between the instruction memory and the datapath and halts on `ecall`.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; must be word-aligned.
- `ECALL_WORD`, 32'h0000_0073: fetched word that halts the unit.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  level; 1 = keep fetching, 0 = park in IDLE after the current instruction.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  32  fetch address; equals `pc` and is stable while `imem_req`=1.
- `imem_ack`  in  1  memory accepted the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched word.
- `issue_ready`  in  1  datapath can accept an instruction this cycle.
- `instr`  out  32  instruction to the datapath, registered.
- `we`  out  1  issue strobe to the datapath; equals (state==ISSUE) & `issue_ready`.
- `pc`  out  32  address of the instruction in `instr` or currently being fetched.
- `icount`  out  32  number of instructions issued.
- `halted`  out  1  sticky; set when `ECALL_WORD` is fetched.

## Operation
- Reset values: state=IDLE, `pc`=`RESET_PC`, `imem_req`=0, `instr`=32'h0000_0013 (NOP), `we`=0, `icount`=0, `halted`=0.
- The FSM has four states: IDLE, REQ, ISSUE and HALT.
- IDLE: `imem_req`=0. If `run`=1, the next state is REQ and `imem_req` rises the next cycle.
- REQ: `imem_req`=1 and `imem_addr`=`pc`, both held until `imem_ack`.
  - On `imem_ack`, if `imem_rdata`==`ECALL_WORD`: next state HALT, `halted`<=1, `instr`<=`imem_rdata`, `imem_req`<=0. No issue occurs.
  - On `imem_ack` with any other word: `instr`<=`imem_rdata`, `imem_req`<=0, next state ISSUE.
  - `run` falling while in REQ does not abort the request. The fetch completes and is issued normally.
- ISSUE: `instr` is held and `we`=`issue_ready`. On the edge where `we`=1:
  - `pc`<=`pc`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `icount`<=`icount`+1, wrapping.
  - Next state is REQ if `run`=1, else IDLE.
  - If `issue_ready`=0, stay in ISSUE with `instr`, `pc` and `icount` unchanged.
- HALT: terminal until `rst`. `imem_req`=0 and `we`=0, and `run` is ignored.
- `imem_ack` while `imem_req`=0 (IDLE/ISSUE/HALT) is ignored and `instr` does not change.
- `pc[1:0]` is always 2'b00.

## Timing
- Reset is asynchronous: asserting `rst` drops `imem_req` and `we` immediately, even mid-request or mid-issue. The outstanding fetch is abandoned and its ack is ignored. Release is synchronous to the next `clk` edge.
- Start latency: `run` sampled 1 at edge N gives `imem_req`=1 in cycle N+1.
- With zero-wait memory (ack in the first REQ cycle) and `issue_ready` held 1, the unit sustains one issue every 2 cycles: REQ, ISSUE, REQ, ISSUE...
- Each memory wait cycle adds one REQ cycle. Each cycle of `issue_ready`=0 adds one ISSUE cycle.
- `we` is high for exactly one cycle per issued instruction. The datapath samples `instr` and `we` on that edge.
- `halted` rises the cycle after the ECALL ack.

## Test plan
- Reset checks: assert `rst` asynchronously mid-cycle. All outputs must take their reset values at once: `pc`=0, `instr`=32'h13, `imem_req`=0, `we`=0, `icount`=0.
- Zero-wait stream: `run`=1, memory acks immediately with 32'h002081B3 (add), 32'h40208233 (sub), 32'h00000013. Require `we` pulses every 2 cycles, fetch addresses 0, 4, 8, and `icount`=3.
- Wait states and backpressure: ack delayed 3 cycles, then `issue_ready`=0 for 2 cycles. Require `imem_addr` stable during the wait, `instr` held, a single `we` pulse, and `pc` advancing by exactly 4.
- `run` drop: deassert `run` during REQ. Require that the fetch completes, one issue occurs, the FSM returns to IDLE and there is no further `imem_req`. Reassert `run` and require fetch to resume at `pc`+4.
- Halt: fetch 32'h00000073 at address 8. Require `halted`=1, no `we`, `instr`=32'h73, and `imem_req` staying 0 with `run`=1 for 10 cycles.
- Wrap and reset mid-request: use `RESET_PC`=32'hFFFF_FFFC. Require the first issue to wrap `pc` to 0. Then assert `rst` during REQ with a later ack. Require the ack to be ignored and `pc`=`RESET_PC`.
